// File: rtl/uart_image_loader.sv
// UART (8N1, LSB first) pixel receiver that fills the image memory sequentially.
// Optional LOADER_CHECKSUM_EN adds a running 8-bit sum of the written bytes.
module uart_image_loader #(
    parameter int unsigned CLK_FREQ = 50_000_000,
    parameter int unsigned BAUD     = 115200,
    parameter int unsigned ADDR_W   = 18,
    parameter int unsigned IMG_SIZE = 65536
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              frame_err,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
`ifdef LOADER_CHECKSUM_EN
    output logic [7:0]        checksum,
`endif
    output logic [7:0]        mem_wdata
);

    localparam int unsigned DIV   = CLK_FREQ / BAUD;
    localparam int unsigned CNT_W = $clog2(DIV + 1);
    localparam int unsigned PIX_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] BAUD_FULL = CNT_W'(DIV);
    localparam logic [CNT_W-1:0] BAUD_HALF = CNT_W'(DIV / 2);
    localparam logic [PIX_W-1:0] LAST_PIX  = PIX_W'(IMG_SIZE - 1);

    typedef enum logic [2:0] {
        StIdle, StWaitSb, StStart, StData, StStop, StWrite, StDone
    } state_e;

    state_e            state_q, state_d;
    logic              rx_meta_q, rx_s_q;
    logic [CNT_W-1:0]  baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;
    logic [PIX_W-1:0]  pix_q, pix_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              ferr_q, ferr_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        wdata_q, wdata_d;
    logic              baud_tick;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        sum_q, sum_d;
`endif

    // rx is asynchronous to clk; flops preset to the idle level
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            pix_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
`ifdef LOADER_CHECKSUM_EN
            sum_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            pix_q   <= pix_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ferr_q  <= ferr_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
`ifdef LOADER_CHECKSUM_EN
            sum_q   <= sum_d;
`endif
        end
    end

    assign baud_tick = (baud_q <= CNT_W'(1));

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pix_d   = pix_q;
        busy_d  = busy_q;
        done_d  = done_q;
        ferr_d  = ferr_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
`ifdef LOADER_CHECKSUM_EN
        sum_d   = sum_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StWaitSb;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    ferr_d  = 1'b0;
                    pix_d   = '0;
`ifdef LOADER_CHECKSUM_EN
                    sum_d   = '0;
`endif
                end
            end
            // Level-sensitive so a held-low line keeps re-framing instead of stalling
            StWaitSb: begin
                if (!rx_s_q) begin
                    state_d = StStart;
                    baud_d  = BAUD_HALF;
                end
            end
            StStart: begin
                if (baud_tick) begin
                    if (!rx_s_q) begin
                        state_d = StData;
                        baud_d  = BAUD_FULL;
                        bit_d   = '0;
                    end else begin
                        state_d = StWaitSb;
                    end
                end else begin
                    baud_d = baud_q - CNT_W'(1);
                end
            end
            StData: begin
                if (baud_tick) begin
                    shift_d = {rx_s_q, shift_q[7:1]};
                    baud_d  = BAUD_FULL;
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = StStop;
                    end
                end else begin
                    baud_d = baud_q - CNT_W'(1);
                end
            end
            StStop: begin
                if (baud_tick) begin
                    if (rx_s_q) begin
                        state_d = StWrite;
                        we_d    = 1'b1;
                        addr_d  = pix_q[ADDR_W-1:0];
                        wdata_d = shift_q;
                    end else begin
                        state_d = StWaitSb;
                        ferr_d  = 1'b1;
                    end
                end else begin
                    baud_d = baud_q - CNT_W'(1);
                end
            end
            StWrite: begin
                pix_d = pix_q + PIX_W'(1);
`ifdef LOADER_CHECKSUM_EN
                sum_d = sum_q + wdata_q;
`endif
                if (pix_q == LAST_PIX) begin
                    state_d = StDone;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    state_d = StWaitSb;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign frame_err = ferr_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
`ifdef LOADER_CHECKSUM_EN
    assign checksum  = sum_q;
`endif

endmodule

// File: tb/tb_uart_image_loader.sv
// Scoreboard bench for uart_image_loader (DIV=10, IMG_SIZE=4).
module tb_uart_image_loader;

    localparam int unsigned CLK_FREQ = 1_000_000;
    localparam int unsigned BAUD     = 100_000;
    localparam int unsigned DIV      = 10;
    localparam int unsigned ADDR_W   = 18;
    localparam int unsigned IMG_SIZE = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              rx = 1'b1;
    logic              start = 1'b0;
    logic              busy, done, frame_err, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        checksum;
`endif

    uart_image_loader #(
        .CLK_FREQ(CLK_FREQ),
        .BAUD    (BAUD),
        .ADDR_W  (ADDR_W),
        .IMG_SIZE(IMG_SIZE)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rx       (rx),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .frame_err(frame_err),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
`ifdef LOADER_CHECKSUM_EN
        .checksum (checksum),
`endif
        .mem_wdata(mem_wdata)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [7:0]        data;
    } wr_t;

    wr_t  exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   writes = 0;
    logic prev_we = 1'b0;
    logic post_done = 1'b0;
    logic post_busy = 1'b0;
    wr_t  exp_wr;

    // Scoreboard monitor: every write cycle must match the next expected (addr,data)
    always @(negedge clk) begin
        if (prev_we) begin
            post_done = done;
            post_busy = busy;
        end
        prev_we = mem_we;
        if (mem_we === 1'b1) begin
            writes++;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write: got addr=%0d data=%02h, required no write",
                         mem_addr, mem_wdata);
            end else begin
                exp_wr = exp_q.pop_front();
                if (mem_addr !== exp_wr.addr || mem_wdata !== exp_wr.data) begin
                    failures++;
                    $display("FAIL write_data: got (%0d,%02h) required (%0d,%02h)",
                             mem_addr, mem_wdata, exp_wr.addr, exp_wr.data);
                end
            end
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        start = 1'b0;
        rx    = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        exp_q.delete();
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop_bit);
        @(posedge clk);
        #1 rx = 1'b0;
        repeat (DIV) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            #1 rx = d[i];
            repeat (DIV) @(posedge clk);
        end
        #1 rx = stop_bit;
        repeat (DIV) @(posedge clk);
        #1 rx = 1'b1;
        repeat (DIV) @(posedge clk);
    endtask

    task automatic push_send(input logic [ADDR_W-1:0] a, input logic [7:0] d);
        exp_q.push_back('{addr: a, data: d});
        send_byte(d, 1'b1);
    endtask

    task automatic test_reset();
        int w0;
        do_reset();
        pulse_start();
        @(posedge clk);
        #1 rx = 1'b0;
        repeat (3 * DIV) @(posedge clk);
        #3 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        rx = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, done, frame_err} !== 3'b000) begin
            failures++;
            $display("FAIL reset_status: got busy/done/ferr=%b required 000",
                     {busy, done, frame_err});
        end
        checks++;
        if (mem_we !== 1'b0) begin
            failures++;
            $display("FAIL reset_we: got %b required 0", mem_we);
        end
        checks++;
        if (mem_addr !== '0 || mem_wdata !== 8'h00) begin
            failures++;
            $display("FAIL reset_mem: got addr=%0d data=%02h required 0/00", mem_addr, mem_wdata);
        end
        w0 = writes;
        pulse_start();
        push_send(0, 8'h11);
        push_send(1, 8'h22);
        push_send(2, 8'h33);
        push_send(3, 8'h44);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || writes - w0 !== 4 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL reset_reload: got done=%b busy=%b writes=%0d pending=%0d required 1 0 4 0",
                     done, busy, writes - w0, exp_q.size());
        end
    endtask

    task automatic test_pixels();
        int w0;
        do_reset();
        w0 = writes;
        pulse_start();
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL pix_busy: got %b required 1", busy);
        end
        push_send(0, 8'hA5);
        checks++;
        if (post_done !== 1'b0 || post_busy !== 1'b1) begin
            failures++;
            $display("FAIL pix_mid_status: got done=%b busy=%b required 0 1", post_done, post_busy);
        end
        push_send(1, 8'h00);
        push_send(2, 8'hFF);
        push_send(3, 8'h3C);
        checks++;
        if (post_done !== 1'b1 || post_busy !== 1'b0) begin
            failures++;
            $display("FAIL pix_done_next_cycle: got done=%b busy=%b required 1 0",
                     post_done, post_busy);
        end
        checks++;
        if (mem_addr !== 18'd3 || mem_wdata !== 8'h3C) begin
            failures++;
            $display("FAIL pix_hold: got (%0d,%02h) required (3,3c)", mem_addr, mem_wdata);
        end
        send_byte(8'h99, 1'b1);
        checks++;
        if (writes - w0 !== 4 || done !== 1'b1) begin
            failures++;
            $display("FAIL pix_after_done: got writes=%0d done=%b required 4 1",
                     writes - w0, done);
        end
    endtask

    task automatic test_frame_err();
        int w0;
        do_reset();
        w0 = writes;
        pulse_start();
        send_byte(8'h5A, 1'b0);
        checks++;
        if (frame_err !== 1'b1 || writes - w0 !== 0) begin
            failures++;
            $display("FAIL ferr_set: got ferr=%b writes=%0d required 1 0", frame_err, writes - w0);
        end
        push_send(0, 8'h5A);
        checks++;
        if (frame_err !== 1'b1 || writes - w0 !== 1) begin
            failures++;
            $display("FAIL ferr_sticky: got ferr=%b writes=%0d required 1 1",
                     frame_err, writes - w0);
        end
        push_send(1, 8'h01);
        push_send(2, 8'h02);
        push_send(3, 8'h03);
        pulse_start();
        @(negedge clk);
        checks++;
        if ({frame_err, done, busy} !== 3'b001) begin
            failures++;
            $display("FAIL ferr_clear: got ferr/done/busy=%b required 001",
                     {frame_err, done, busy});
        end
    endtask

    task automatic test_glitch();
        int w0;
        do_reset();
        w0 = writes;
        pulse_start();
        @(posedge clk);
        #1 rx = 1'b0;
        repeat (3) @(posedge clk);
        #1 rx = 1'b1;
        repeat (3 * DIV) @(posedge clk);
        checks++;
        if (writes - w0 !== 0 || frame_err !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL glitch: got writes=%0d ferr=%b busy=%b required 0 0 1",
                     writes - w0, frame_err, busy);
        end
        push_send(0, 8'h77);
        checks++;
        if (writes - w0 !== 1) begin
            failures++;
            $display("FAIL glitch_recover: got writes=%0d required 1", writes - w0);
        end
    endtask

    task automatic test_back_to_back();
        int w0;
        bit hit;
        do_reset();
        w0 = writes;
        pulse_start();
        push_send(0, 8'h10);
        push_send(1, 8'h20);
        pulse_start();
        push_send(2, 8'h30);
        exp_q.push_back('{addr: 18'd3, data: 8'h40});
        hit = 1'b0;
        fork
            send_byte(8'h40, 1'b1);
            begin
                // raise start during the final write cycle
                for (int c = 0; c < 20 * DIV && !hit; c++) begin
                    @(negedge clk);
                    if (mem_we === 1'b1) begin
                        start = 1'b1;
                        hit = 1'b1;
                        @(posedge clk);
                        #1 start = 1'b0;
                    end
                end
            end
        join
        checks++;
        if (!hit) begin
            failures++;
            $display("FAIL b2b_last_write_timeout: got no write, required write at addr 3");
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || writes - w0 !== 4 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL b2b_status: got done=%b busy=%b writes=%0d pending=%0d required 1 0 4 0",
                     done, busy, writes - w0, exp_q.size());
        end
    endtask

    task automatic test_break();
        int w0;
        do_reset();
        w0 = writes;
        pulse_start();
        @(posedge clk);
        #1 rx = 1'b0;
        // two full framing periods; release lands in the third start bit
        repeat (194) @(posedge clk);
        #1 rx = 1'b1;
        repeat (2 * DIV) @(posedge clk);
        checks++;
        if (frame_err !== 1'b1 || writes - w0 !== 0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL break: got ferr=%b writes=%0d busy=%b required 1 0 1",
                     frame_err, writes - w0, busy);
        end
        push_send(0, 8'hC3);
        checks++;
        if (writes - w0 !== 1) begin
            failures++;
            $display("FAIL break_recover: got writes=%0d required 1", writes - w0);
        end
    endtask

`ifdef LOADER_CHECKSUM_EN
    task automatic test_checksum();
        do_reset();
        pulse_start();
        push_send(0, 8'h80);
        push_send(1, 8'h80);
        push_send(2, 8'h01);
        push_send(3, 8'h02);
        checks++;
        if (checksum !== 8'h03) begin
            failures++;
            $display("FAIL checksum: got %02h required 03", checksum);
        end
        pulse_start();
        @(negedge clk);
        checks++;
        if (checksum !== 8'h00) begin
            failures++;
            $display("FAIL checksum_clear: got %02h required 00", checksum);
        end
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_pixels();
        test_frame_err();
        test_glitch();
        test_back_to_back();
        test_break();
`ifdef LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
